nubus_arbiter: RTL and testbench
================================

Name: nubus_arbiter

Overview:
NuBus distributed-arbitration controller for the card's master path. It contends for bus ownership on the shared open-collector /RQST and /ARB[3:0] lines using the card's slot ID, and applies NuBus fairness. It tracks bus-busy from START/ACK and hands a grant to the master FSM. It sits beside the slave FSM and master FSM, sampling the same NuBus inputs on the rising edge of nub_clkn.

Parameters:
ARB_SETTLE, 2, cycles ARB lines must settle after an arbitration round begins before the win/lose sample (1..7).
ARB_TIMEOUT, 255, cycles allowed in ARB+WON before abort; 0 disables the watchdog.
TIMEOUT_W, 8, watchdog counter width; must hold ARB_TIMEOUT.

Ports:
nub_clkn  in  1  NuBus clock; all state updates on posedge.
nub_resetn  in  1  asynchronous active-low reset.
nub_idn  in  4  card slot ID, active low.
nub_arbn_i  in  4  sensed /ARB bus lines (wired-AND result).
nub_rqstn_i  in  1  sensed /RQST bus line.
nub_startn  in  1  sensed /START.
nub_ackn  in  1  sensed /ACK.
mst_req  in  1  master requests bus ownership; level, held until grant or withdrawal.
mst_lock  in  1  master keeps ownership after the current transaction (ARB_LOCK_EN only).
nub_rqstn_o  out  1  /RQST drive; 0 = pull low, 1 = release.
nub_arbn_o  out  4  /ARB drive per bit; 0 = pull low, 1 = release.
arb_grant_o  out  1  master owns the bus and may assert START.
arb_busy_o  out  1  another transaction is in progress on the bus.
arb_timeout_o  out  1  one-cycle pulse when the watchdog aborts a contest.

Behaviour:
- Definitions: id = ~nub_idn; bus = ~nub_arbn_i; rq = ~nub_rqstn_i; start = ~nub_startn; ack = ~nub_ackn.
- Reset: state IDLE; nub_rqstn_o=1; nub_arbn_o=4'hF; arb_grant_o=0; arb_busy_o=0; arb_timeout_o=0; counters 0. Reset asserted mid-contest or mid-ownership releases all lines asynchronously.
- busy flag: set on start & ~ack; cleared on ack; start & ack in the same cycle leaves busy unchanged. Drives arb_busy_o directly.
- Drive logic, combinational, used only in ARB and WON; otherwise 4'hF:
  - d3 = id3
  - d2 = id2 & (id3 | ~bus3)
  - d1 = id1 & (id3 | ~bus3) & (id2 | ~bus2)
  - d0 = id0 & all higher bits matching
  - nub_arbn_o = ~d.
- States:
  - IDLE: mst_req & ~rq -> ARB. mst_req & rq -> FAIR.
  - FAIR: lines released. ~rq -> ARB. ~mst_req -> IDLE.
  - ARB: nub_rqstn_o=0. The settle counter loads at entry and on every start cycle, then counts down. At count 0: bus==id -> WON; otherwise stay in ARB and wait for the next start, which restarts the round. ~mst_req -> IDLE with lines released next cycle.
  - WON: keep driving RQST and ARB. Once ~busy, or ack is seen this cycle -> OWN.
  - OWN: arb_grant_o=1. RQST and ARB are released on the cycle the card's own start is sampled. The first ack after that start -> IDLE and grant drops the same edge. The master must withdraw mst_req, which the master FSM handles in the same cycle.
- Watchdog counts cycles spent in ARB+WON; cleared on entry to ARB. Reaching ARB_TIMEOUT -> IDLE and arb_timeout_o pulses once. Re-entry after a timeout obeys fairness (IDLE -> FAIR if rq).
- Simultaneous events: mst_req falling on the same edge as the WON condition -> IDLE (withdrawal wins). A timeout on the same edge as a win -> WON (win wins).
- Latency: lone requester on an idle bus gets grant ARB_SETTLE+2 edges after mst_req is sampled (entry edge, settle, OWN edge).

Optional Feature:
ARB_LOCK_EN. When defined, mst_lock=1 at the ack ending an owned transaction keeps the state in OWN with arb_grant_o=1. No re-arbitration occurs, and RQST stays released. Ownership ends at the first ack seen with mst_lock=0. When not defined, mst_lock is ignored and every transaction re-arbitrates.

Decomposition:
- nubus_pkg holds:
  - arb_state_t enum (IDLE, FAIR, ARB, WON, OWN)
  - NUBUS_ID_W=4
  - ARB_LINES=4
- nubus_arb_drive is a purely combinational sub-module with inputs id[3:0] and bus[3:0] and output drive[3:0]. It is reused by the bench's model of the competing card.

Test Plan:
- Lone card id=4'hA, rq idle, mst_req=1, ARB_SETTLE=2, bench wires the bus to echo the drive -> nub_rqstn_o=0 and nub_arbn_o=4'h5 one edge later; arb_grant_o=1 4 edges after mst_req.
- Contest id=4'hA against modelled card 4'hC (wired-AND) -> bus settles to 4'hC; this card stays in ARB with no grant. After the rival's start+ack, the next start round with no rival -> grant.
- Fairness: nub_rqstn_i=0 held by another card when mst_req rises -> state FAIR, nub_rqstn_o stays 1. Grant follows only after nub_rqstn_i returns to 1 and a round is won.
- Busy bus: win while a foreign start without ack is outstanding -> stays in WON. Foreign ack -> arb_grant_o=1 on the next edge.
- Watchdog: ARB_TIMEOUT=8, bus forced to 4'hF -> arb_timeout_o high for exactly one cycle at cycle 8 and lines released. Then assert nub_resetn=0 during a new ARB -> all outputs return to reset values immediately.
- ARB_LOCK_EN defined: two back-to-back owned transactions with mst_lock=1 at the first ack -> grant stays 1 with no RQST re-assertion. Without the macro, grant drops after the first ack.

Source files
------------

// File: rtl/nubus_pkg.sv
// -----------------------------------------------------------------------------
// nubus_pkg
// Shared types and sizes for the NuBus master-path arbitration logic.
//   arb_state_t : arbitration controller states
//   NUBUS_ID_W  : width of the card slot ID
//   ARB_LINES   : number of /ARB lines on the bus
// -----------------------------------------------------------------------------
package nubus_pkg;

    localparam int NUBUS_ID_W = 4;
    localparam int ARB_LINES  = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FAIR = 3'd1,
        ARB  = 3'd2,
        WON  = 3'd3,
        OWN  = 3'd4
    } arb_state_t;

endpackage

// File: rtl/nubus_arb_drive.sv
// -----------------------------------------------------------------------------
// nubus_arb_drive
// Combinational /ARB drive pattern for NuBus distributed arbitration. A card
// keeps asserting a lower ID bit only while every higher bit it sees on the
// bus matches its own ID; as soon as a higher bus bit is active where the own
// ID bit is 0, all lower bits back off.
// Ports (all active-high):
//   id    : card slot ID
//   bus   : sensed /ARB lines (active bits of the wired-AND)
//   drive : bits this card wants to pull low
// -----------------------------------------------------------------------------
module nubus_arb_drive
    import nubus_pkg::*;
(
    input  logic [NUBUS_ID_W-1:0] id,
    input  logic [ARB_LINES-1:0]  bus,
    output logic [ARB_LINES-1:0]  drive
);

    // keep_n: all bits above n are either our own 1 or not active on the bus
    logic keep_2;
    logic keep_1;
    logic keep_0;

    assign keep_2 = id[3] | ~bus[3];
    assign keep_1 = keep_2 & (id[2] | ~bus[2]);
    assign keep_0 = keep_1 & (id[1] | ~bus[1]);

    assign drive[3] = id[3];
    assign drive[2] = id[2] & keep_2;
    assign drive[1] = id[1] & keep_1;
    assign drive[0] = id[0] & keep_0;

endmodule

// File: rtl/nubus_arbiter.sv
// -----------------------------------------------------------------------------
// nubus_arbiter
// NuBus distributed-arbitration controller for the card's master path.
// Contends on /RQST and /ARB[3:0] with the card's slot ID, applies fairness
// (no new request while another card holds /RQST), tracks bus-busy from
// START/ACK and grants ownership to the master FSM.
//
// Ports:
//   nub_clkn      : NuBus clock, all state on posedge
//   nub_resetn    : asynchronous active-low reset
//   nub_idn       : slot ID, active low
//   nub_arbn_i    : sensed /ARB lines
//   nub_rqstn_i   : sensed /RQST
//   nub_startn    : sensed /START
//   nub_ackn      : sensed /ACK
//   mst_req       : master requests ownership (level)
//   mst_lock      : keep ownership after current transaction
//   nub_rqstn_o   : /RQST drive (0 = pull low)
//   nub_arbn_o    : /ARB drive per bit (0 = pull low)
//   arb_grant_o   : master owns the bus
//   arb_busy_o    : a transaction is in progress on the bus
//   arb_timeout_o : one-cycle pulse on watchdog abort
//
// Build option: define ARB_LOCK_EN to let mst_lock hold ownership across
// back-to-back transactions.
// -----------------------------------------------------------------------------
module nubus_arbiter
    import nubus_pkg::*;
#(
    parameter int ARB_SETTLE  = 2,
    parameter int ARB_TIMEOUT = 255,
    parameter int TIMEOUT_W   = 8
) (
    input  logic                  nub_clkn,
    input  logic                  nub_resetn,
    input  logic [NUBUS_ID_W-1:0] nub_idn,
    input  logic [ARB_LINES-1:0]  nub_arbn_i,
    input  logic                  nub_rqstn_i,
    input  logic                  nub_startn,
    input  logic                  nub_ackn,
    input  logic                  mst_req,
    input  logic                  mst_lock,
    output logic                  nub_rqstn_o,
    output logic [ARB_LINES-1:0]  nub_arbn_o,
    output logic                  arb_grant_o,
    output logic                  arb_busy_o,
    output logic                  arb_timeout_o
);

    // Settle counter counts down to 0; loading SETTLE-1 gives SETTLE cycles in ARB
    localparam logic [2:0]           SETTLE_LOAD = 3'(ARB_SETTLE - 1);
    localparam logic [TIMEOUT_W-1:0] WD_LAST     = TIMEOUT_W'(ARB_TIMEOUT - 1);
    localparam bit                   WD_EN       = (ARB_TIMEOUT != 0);

    logic [NUBUS_ID_W-1:0] id;
    logic [ARB_LINES-1:0]  bus;
    logic [ARB_LINES-1:0]  drive;
    logic                  rq;
    logic                  start;
    logic                  ack;

    arb_state_t            state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  to_q, to_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  pend_q, pend_d;
    logic [TIMEOUT_W-1:0]  wd_q, wd_d;
    logic                  started_q, started_d;
    logic                  rel_q, rel_d;

    logic                  win;
    logic                  wd_expire;
    logic                  own_end;
    logic                  own_hold;
    logic                  enter_arb;
    logic                  abort;

    assign id    = ~nub_idn;
    assign bus   = ~nub_arbn_i;
    assign rq    = ~nub_rqstn_i;
    assign start = ~nub_startn;
    assign ack   = ~nub_ackn;

    nubus_arb_drive u_drive (
        .id    (id),
        .bus   (bus),
        .drive (drive)
    );

    // One win/lose sample per round; a START during the round restarts it
    assign win       = (state_q == ARB) && pend_q && (cnt_q == 3'd0) && !start && (bus == id);
    assign wd_expire = WD_EN && (wd_q == WD_LAST);
    assign own_end   = started_q && ack;
    assign enter_arb = (state_d == ARB) && (state_q != ARB);

`ifdef ARB_LOCK_EN
    assign own_hold = mst_lock;
`else
    logic lock_unused;
    assign lock_unused = mst_lock;
    assign own_hold    = 1'b0;
`endif

    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mst_req) state_d = rq ? FAIR : ARB;
            end
            FAIR: begin
                if (!mst_req)  state_d = IDLE;
                else if (!rq)  state_d = ARB;
            end
            ARB: begin
                // withdrawal beats a win, a win beats the watchdog
                if (!mst_req) begin
                    state_d = IDLE;
                end else if (win) begin
                    state_d = WON;
                end else if (wd_expire) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end
            end
            WON: begin
                if (!mst_req) begin
                    state_d = IDLE;
                end else if (!busy_q || ack) begin
                    state_d = OWN;
                end else if (wd_expire) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end
            end
            OWN: begin
                if (own_end && !own_hold) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        nub_rqstn_o = 1'b1;
        nub_arbn_o  = '1;
        arb_grant_o = 1'b0;
        case (state_q)
            ARB, WON: begin
                nub_rqstn_o = 1'b0;
                nub_arbn_o  = ~drive;
            end
            OWN: begin
                arb_grant_o = 1'b1;
                // lines stay asserted until our own START has been sampled
                if (!rel_q) begin
                    nub_rqstn_o = 1'b0;
                    nub_arbn_o  = ~drive;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_d = busy_q;
        if (start && !ack)      busy_d = 1'b1;
        else if (ack && !start) busy_d = 1'b0;

        cnt_d  = cnt_q;
        pend_d = pend_q;
        if (enter_arb || ((state_q == ARB) && start)) begin
            cnt_d  = SETTLE_LOAD;
            pend_d = 1'b1;
        end else if (state_q == ARB) begin
            if (cnt_q != 3'd0) cnt_d  = cnt_q - 3'd1;
            else               pend_d = 1'b0;
        end

        wd_d = wd_q;
        if (enter_arb) begin
            wd_d = '0;
        end else if (WD_EN && ((state_q == ARB) || (state_q == WON))) begin
            wd_d = wd_q + TIMEOUT_W'(1);
        end

        started_d = started_q;
        rel_d     = rel_q;
        if (state_d != OWN) begin
            started_d = 1'b0;
            rel_d     = 1'b0;
        end else if (state_q == OWN) begin
            // a locked continuation waits for the next START; lines stay released
            if (own_end)    started_d = 1'b0;
            else if (start) begin
                started_d = 1'b1;
                rel_d     = 1'b1;
            end
        end

        to_d = abort;
    end

    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            busy_q    <= 1'b0;
            to_q      <= 1'b0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            wd_q      <= '0;
            started_q <= 1'b0;
            rel_q     <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            to_q      <= to_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            wd_q      <= wd_d;
            started_q <= started_d;
            rel_q     <= rel_d;
        end
    end

    assign arb_busy_o    = busy_q;
    assign arb_timeout_o = to_q;

endmodule

// File: tb/tb_nubus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nubus_arbiter
// Cycle-by-cycle vector table for the NuBus arbiter. Each record holds the bus
// inputs for one clock and the expected {rqstn, arbn, grant, busy, timeout}
// after that edge. The /ARB bus is modelled as a register updated on the
// falling edge from this card's drive and an optional rival card (ID 4'hC).
// -----------------------------------------------------------------------------
module tb_nubus_arbiter;
    import nubus_pkg::*;

    localparam logic [3:0] MY_ID    = 4'hA;
    localparam logic [3:0] RIVAL_ID = 4'hC;

`ifdef ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic       nub_clkn = 1'b0;
    logic       nub_resetn;
    logic [3:0] nub_idn;
    logic [3:0] nub_arbn_i;
    logic       nub_rqstn_i;
    logic       nub_startn;
    logic       nub_ackn;
    logic       mst_req;
    logic       mst_lock;
    logic       nub_rqstn_o;
    logic [3:0] nub_arbn_o;
    logic       arb_grant_o;
    logic       arb_busy_o;
    logic       arb_timeout_o;

    logic [3:0] bus_q;
    logic [3:0] rival_d;
    logic [7:0] act;

    always #5 nub_clkn = ~nub_clkn;

    assign nub_arbn_i = ~bus_q;
    assign act = {nub_rqstn_o, nub_arbn_o, arb_grant_o, arb_busy_o, arb_timeout_o};

    nubus_arbiter #(
        .ARB_SETTLE  (2),
        .ARB_TIMEOUT (8),
        .TIMEOUT_W   (8)
    ) dut (
        .nub_clkn      (nub_clkn),
        .nub_resetn    (nub_resetn),
        .nub_idn       (nub_idn),
        .nub_arbn_i    (nub_arbn_i),
        .nub_rqstn_i   (nub_rqstn_i),
        .nub_startn    (nub_startn),
        .nub_ackn      (nub_ackn),
        .mst_req       (mst_req),
        .mst_lock      (mst_lock),
        .nub_rqstn_o   (nub_rqstn_o),
        .nub_arbn_o    (nub_arbn_o),
        .arb_grant_o   (arb_grant_o),
        .arb_busy_o    (arb_busy_o),
        .arb_timeout_o (arb_timeout_o)
    );

    nubus_arb_drive u_rival (
        .id    (RIVAL_ID),
        .bus   (bus_q),
        .drive (rival_d)
    );

    typedef struct {
        string      name;
        bit         req, rq, st, ak, lk, riv, frc;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        int         idx;
        logic [7:0] exp;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [7:0] E(input bit r, input logic [3:0] a,
                                     input bit g, input bit b, input bit t);
        return {r, a, g, b, t};
    endfunction

    function automatic void add(input string n, input bit req, input bit rq,
                                input bit st, input bit ak, input bit lk,
                                input bit riv, input bit frc, input logic [7:0] e);
        vec_t v;
        v.name = n; v.req = req; v.rq = rq; v.st = st; v.ak = ak;
        v.lk = lk; v.riv = riv; v.frc = frc; v.exp = e;
        tbl.push_back(v);
    endfunction

    task automatic check(input string n, input int idx, input logic [7:0] a,
                         input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s step %0d: got {rqstn,arbn,grant,busy,to}=%02h, expected %02h",
                     n, idx, a, e);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        sb_t s;
        @(negedge nub_clkn);
        if (v.frc) bus_q = 4'h0;
        else       bus_q = ~nub_arbn_o | (v.riv ? rival_d : 4'h0);
        mst_req     = v.req;
        nub_rqstn_i = ~v.rq;
        nub_startn  = ~v.st;
        nub_ackn    = ~v.ak;
        mst_lock    = v.lk;
        s.name = v.name; s.idx = idx; s.exp = v.exp;
        sbq.push_back(s);
        @(posedge nub_clkn);
        #1;
        s = sbq.pop_front();
        check(s.name, s.idx, act, s.exp);
    endtask

    initial begin
        //   name        req rq st ak lk riv frc  expected after edge
        // lone card, bus echoes drive; ownership, own START/ACK, lock option
        add("lone",      1, 0, 0, 0, 0, 0, 0, E(0, 4'h5, 0, 0, 0));
        add("lone",      1, 0, 0, 0, 0, 0, 0, E(0, 4'h5, 0, 0, 0));
        add("lone",      1, 0, 0, 0, 0, 0, 0, E(0, 4'h5, 0, 0, 0));
        add("lone",      1, 0, 0, 0, 0, 0, 0, E(0, 4'h5, 1, 0, 0));
        add("lone",      1, 0, 1, 0, 1, 0, 0, E(1, 4'hF, 1, 1, 0));
        add("lock",      0, 0, 0, 1, 1, 0, 0, E(1, 4'hF, LOCK, 0, 0));
        add("lock",      0, 0, 1, 0, 0, 0, 0, E(1, 4'hF, LOCK, 1, 0));
        add("lock",      0, 0, 0, 1, 0, 0, 0, E(1, 4'hF, 0, 0, 0));
        // withdrawal during ARB
        add("withdraw",  1, 0, 0, 0, 0, 0, 0, E(0, 4'h5, 0, 0, 0));
        add("withdraw",  0, 0, 0, 0, 0, 0, 0, E(1, 4'hF, 0, 0, 0));
        add("withdraw",  0, 0, 0, 0, 0, 0, 0, E(1, 4'hF, 0, 0, 0));
        // fairness: another card holds /RQST
        add("fair",      1, 1, 0, 0, 0, 0, 0, E(1, 4'hF, 0, 0, 0));
        add("fair",      1, 1, 0, 0, 0, 0, 0, E(1, 4'hF, 0, 0, 0));
        add("fair",      1, 0, 0, 0, 0, 0, 0, E(0, 4'h5, 0, 0, 0));
        add("fair",      1, 0, 0, 0, 0, 0, 0, E(0, 4'h5, 0, 0, 0));
        add("fair",      1, 0, 0, 0, 0, 0, 0, E(0, 4'h5, 0, 0, 0));
        add("fair",      1, 0, 0, 0, 0, 0, 0, E(0, 4'h5, 1, 0, 0));
        add("fair",      1, 0, 1, 0, 0, 0, 0, E(1, 4'hF, 1, 1, 0));
        add("fair",      0, 0, 0, 1, 0, 0, 0, E(1, 4'hF, 0, 0, 0));
        // contest against 4'hC, then rival START, win while busy, rival ACK
        add("contest",   1, 0, 0, 0, 0, 1, 0, E(0, 4'h7, 0, 0, 0));
        add("contest",   1, 0, 0, 0, 0, 1, 0, E(0, 4'h7, 0, 0, 0));
        add("contest",   1, 0, 0, 0, 0, 1, 0, E(0, 4'h7, 0, 0, 0));
        add("contest",   1, 0, 1, 0, 0, 0, 0, E(0, 4'h5, 0, 1, 0));
        add("contest",   1, 0, 0, 0, 0, 0, 0, E(0, 4'h5, 0, 1, 0));
        add("busywin",   1, 0, 0, 0, 0, 0, 0, E(0, 4'h5, 0, 1, 0));
        add("busywin",   1, 0, 0, 0, 0, 0, 0, E(0, 4'h5, 0, 1, 0));
        add("busywin",   1, 0, 0, 1, 0, 0, 0, E(0, 4'h5, 1, 0, 0));
        add("busywin",   1, 0, 1, 0, 0, 0, 0, E(1, 4'hF, 1, 1, 0));
        add("busywin",   0, 0, 0, 1, 0, 0, 0, E(1, 4'hF, 0, 0, 0));
        // busy flag: start, start+ack (hold), ack, start+ack (hold)
        add("busy",      0, 0, 1, 0, 0, 0, 0, E(1, 4'hF, 0, 1, 0));
        add("busy",      0, 0, 1, 1, 0, 0, 0, E(1, 4'hF, 0, 1, 0));
        add("busy",      0, 0, 0, 1, 0, 0, 0, E(1, 4'hF, 0, 0, 0));
        add("busy",      0, 0, 1, 1, 0, 0, 0, E(1, 4'hF, 0, 0, 0));
        // watchdog: bus stuck idle, 8 cycles in ARB then abort
        for (int i = 0; i < 8; i++)
            add("watchdog", 1, 0, 0, 0, 0, 0, 1, E(0, 4'h5, 0, 0, 0));
        add("watchdog",  1, 0, 0, 0, 0, 0, 1, E(1, 4'hF, 0, 0, 1));
        add("refair",    1, 1, 0, 0, 0, 0, 1, E(1, 4'hF, 0, 0, 0));
        add("refair",    1, 0, 0, 0, 0, 0, 1, E(0, 4'h5, 0, 0, 0));

        nub_resetn  = 1'b0;
        nub_idn     = ~MY_ID;
        nub_rqstn_i = 1'b1;
        nub_startn  = 1'b1;
        nub_ackn    = 1'b1;
        mst_req     = 1'b0;
        mst_lock    = 1'b0;
        bus_q       = 4'h0;

        #1;
        check("reset", 0, act, E(1, 4'hF, 0, 0, 0));
        repeat (2) @(posedge nub_clkn);
        @(negedge nub_clkn);
        nub_resetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

        // asynchronous reset in the middle of a new ARB round
        #2;
        nub_resetn = 1'b0;
        #1;
        check("reset_mid_arb", 0, act, E(1, 4'hF, 0, 0, 0));
        @(posedge nub_clkn);
        #1;
        check("reset_held", 1, act, E(1, 4'hF, 0, 0, 0));
        @(negedge nub_clkn);
        mst_req    = 1'b0;
        nub_resetn = 1'b1;
        @(posedge nub_clkn);
        #1;
        check("reset_release", 2, act, E(1, 4'hF, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
